decay_timer: RTL and testbench

DECAY_TIMER -- requirements
Module: decay_timer

---
 rtl/muon_pkg.sv | 18 +
 rtl/event_fifo.sv | 60 ++++++
 rtl/decay_timer.sv | 104 ++++++++++
 tb/tb_decay_timer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muon_pkg.sv
// Shared defaults, state encoding and helpers for the muon decay timing chain.
package muon_pkg;

    localparam int DEF_CNT_WIDTH      = 16;
    localparam int DEF_TIMEOUT_CYCLES = 2000;
    localparam int DEF_FIFO_DEPTH     = 8;
    localparam int STAT_WIDTH         = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        TIMING = 1'b1
    } timer_state_t;

    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] value);
        return (value == {STAT_WIDTH{1'b1}}) ? value : value + STAT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/event_fifo.sv
// First-word-fall-through event buffer: the head entry is presented whenever the buffer is non-empty.
// DEPTH must be a power of two, at least 2, so the pointers wrap naturally.
module event_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    fill;
    logic             do_push;
    logic             do_pop;

    assign empty    = (fill == '0);
    assign full     = (fill == CW'(DEPTH));
    assign do_pop   = pop && !empty;
    // A full buffer still accepts a push when the head leaves on the same edge.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   fill <= fill + CW'(1);
                2'b01:   fill <= fill - CW'(1);
                default: fill <= fill;
            endcase
        end
    end

endmodule

// File: rtl/decay_timer.sv
// Muon decay interval timer: counts cycles from a start coincidence to a decay-electron stop
// and queues each interval for readout, tallying timeouts and buffer overflows.
module decay_timer
    import muon_pkg::*;
#(
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_pulse,
    input  logic                  stop_pulse,
    input  logic                  enable,
    output logic [CNT_WIDTH-1:0]  evt_data,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic                  busy,
    output logic [STAT_WIDTH-1:0] timeout_count,
    output logic [STAT_WIDTH-1:0] drop_count
);

    timer_state_t         state;
    timer_state_t         state_next;
    logic [CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0] count_next;
    logic [CNT_WIDTH-1:0] count_inc;
    logic                 push;
    logic                 timeout_hit;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;
    logic                 drop;

    assign count_inc = count + CNT_WIDTH'(1);
    assign busy      = (state == TIMING);
    assign evt_valid = !fifo_empty;
    assign pop       = evt_valid && evt_ready;
    assign drop      = push && fifo_full && !pop;

    always_comb begin
        state_next  = state;
        count_next  = count;
        push        = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (start_pulse && enable) begin
                    state_next = TIMING;
                    count_next = '0;
                end
            end
            TIMING: begin
                // Losing enable wins over everything, including a stop on the same edge.
                if (!enable) begin
                    state_next = IDLE;
                end else begin
                    count_next = count_inc;
                    if (stop_pulse) begin
                        push       = 1'b1;
                        state_next = IDLE;
                    end else if (count_inc == CNT_WIDTH'(TIMEOUT_CYCLES)) begin
                        timeout_hit = 1'b1;
                        state_next  = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            count         <= '0;
            timeout_count <= '0;
            drop_count    <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (timeout_hit) begin
                timeout_count <= sat_inc(timeout_count);
            end
            if (drop) begin
                drop_count <= sat_inc(drop_count);
            end
        end
    end

    event_fifo #(
        .WIDTH (CNT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_event_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (count_inc),
        .full      (fifo_full),
        .pop       (evt_ready),
        .pop_data  (evt_data),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_decay_timer.sv
// Self-checking bench for decay_timer: table-driven single measurements plus hand-written
// overflow, abort and reset sequences, with a scoreboard checking every buffer read.
module tb_decay_timer;

    localparam int TIMEOUT = 100;
    localparam int K_STOP    = 0;
    localparam int K_TIMEOUT = 1;
    localparam int K_ABORT   = 2;

    typedef struct {
        int kind;
        int k;
        int retrig_j;
        bit stop_on_start;
        bit stop_with_abort;
        bit start_on_exit;
        bit exp_push;
        int exp_to;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_pulse;
    logic        stop_pulse;
    logic        enable;
    logic        evt_ready;
    logic        evt_valid;
    logic        busy;
    logic [15:0] evt_data;
    logic [15:0] timeout_count;
    logic [15:0] drop_count;

    int   checks = 0;
    int   passes = 0;
    int   sb_q[$];
    int   exp_timeouts = 0;
    vec_t vecs[8];

    decay_timer #(
        .CNT_WIDTH      (16),
        .TIMEOUT_CYCLES (TIMEOUT),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_pulse   (start_pulse),
        .stop_pulse    (stop_pulse),
        .enable        (enable),
        .evt_data      (evt_data),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .busy          (busy),
        .timeout_count (timeout_count),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Every accepted read must match the oldest expected interval.
    always @(negedge clk) begin
        if (rst_n && evt_valid && evt_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                $display("[TB] FAIL sb_unexpected_pop: got %0d, expected no entry", evt_data);
            end else begin
                checkOutput("sb_data", {16'd0, evt_data}, sb_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input int idx, input vec_t v);
        int exit_j;
        exit_j      = (v.kind == K_TIMEOUT) ? TIMEOUT : v.k;
        start_pulse = 1'b1;
        enable      = 1'b1;
        stop_pulse  = v.stop_on_start;
        tick();
        start_pulse = 1'b0;
        stop_pulse  = 1'b0;
        checkOutput($sformatf("vec%0d_busy_armed", idx), {31'd0, busy}, 1);
        for (int j = 1; j <= exit_j; j++) begin
            start_pulse = (j == v.retrig_j) || ((j == exit_j) && v.start_on_exit);
            stop_pulse  = (j == exit_j) && ((v.kind == K_STOP) || v.stop_with_abort);
            enable      = !((j == exit_j) && (v.kind == K_ABORT));
            if ((j == exit_j) && v.exp_push) begin
                sb_q.push_back(v.k);
            end
            tick();
            if (j == exit_j - 1) begin
                checkOutput($sformatf("vec%0d_busy_before_exit", idx), {31'd0, busy}, 1);
            end
        end
        start_pulse = 1'b0;
        stop_pulse  = 1'b0;
        enable      = 1'b1;
        exp_timeouts += v.exp_to;
        checkOutput($sformatf("vec%0d_busy_after_exit", idx), {31'd0, busy}, 0);
        checkOutput($sformatf("vec%0d_valid", idx), {31'd0, evt_valid}, {31'd0, v.exp_push});
        checkOutput($sformatf("vec%0d_data", idx), {16'd0, evt_data}, v.exp_push ? v.k : 0);
        checkOutput($sformatf("vec%0d_timeouts", idx), {16'd0, timeout_count}, exp_timeouts);
        tick();
        checkOutput($sformatf("vec%0d_idle_busy", idx), {31'd0, busy}, 0);
        tick();
    endtask

    task automatic do_measure(input int k, input bit pulse_ready);
        start_pulse = 1'b1;
        enable      = 1'b1;
        tick();
        start_pulse = 1'b0;
        for (int j = 1; j <= k; j++) begin
            if (j == k) begin
                stop_pulse = 1'b1;
                if (pulse_ready) evt_ready = 1'b1;
            end
            tick();
            stop_pulse = 1'b0;
        end
        if (pulse_ready) evt_ready = 1'b0;
        tick();
    endtask

    task automatic drain(input string name);
        evt_ready = 1'b1;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
            tick();
        end
        checkOutput({name, "_drained"}, sb_q.size(), 0);
        tick();
        checkOutput({name, "_valid_low"}, {31'd0, evt_valid}, 0);
    endtask

    initial begin
        vecs[0] = '{K_STOP,    37,  0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        vecs[1] = '{K_TIMEOUT,  0,  0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        vecs[2] = '{K_STOP,   100,  0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        vecs[3] = '{K_STOP,     1,  0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        vecs[4] = '{K_ABORT,   20,  0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[5] = '{K_ABORT,   10,  0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        vecs[6] = '{K_STOP,    12,  5, 1'b1, 1'b0, 1'b0, 1'b1, 0};
        vecs[7] = '{K_STOP,    99,  0, 1'b0, 1'b0, 1'b0, 1'b1, 0};

        rst_n       = 1'b0;
        start_pulse = 1'b0;
        stop_pulse  = 1'b0;
        enable      = 1'b0;
        evt_ready   = 1'b1;
        tick();
        tick();
        checkOutput("reset_busy",     {31'd0, busy},      0);
        checkOutput("reset_valid",    {31'd0, evt_valid}, 0);
        checkOutput("reset_data",     {16'd0, evt_data},  0);
        checkOutput("reset_timeouts", {16'd0, timeout_count}, 0);
        checkOutput("reset_drops",    {16'd0, drop_count},    0);
        rst_n  = 1'b1;
        enable = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            applyStimulus(i, vecs[i]);
        end

        // Overflow: a depth-4 buffer keeps the first four intervals and drops the fifth.
        evt_ready = 1'b0;
        for (int k = 5; k <= 9; k++) begin
            if (k <= 8) sb_q.push_back(k);
            do_measure(k, 1'b0);
        end
        checkOutput("ovf_drops", {16'd0, drop_count}, 1);
        checkOutput("ovf_head",  {16'd0, evt_data},   5);
        drain("ovf");

        // Full buffer with a pop on the push edge: both succeed, nothing dropped.
        evt_ready = 1'b0;
        for (int k = 2; k <= 6; k++) begin
            sb_q.push_back(k);
            do_measure(k, k == 6);
        end
        checkOutput("full_pushpop_drops", {16'd0, drop_count}, 1);
        checkOutput("full_pushpop_head",  {16'd0, evt_data},   3);
        drain("full_pushpop");

        // Abort at k=20, then a stop at k=30 arrives while idle.
        start_pulse = 1'b1;
        enable      = 1'b1;
        tick();
        start_pulse = 1'b0;
        for (int j = 1; j <= 30; j++) begin
            enable     = (j != 20);
            stop_pulse = (j == 30);
            tick();
            if (j == 19) checkOutput("abort_busy_before", {31'd0, busy}, 1);
            if (j == 20) checkOutput("abort_busy_after",  {31'd0, busy}, 0);
        end
        stop_pulse = 1'b0;
        enable     = 1'b1;
        checkOutput("abort_late_stop_valid", {31'd0, evt_valid}, 0);
        tick();

        // Asynchronous reset in the middle of a window with two entries buffered.
        evt_ready = 1'b0;
        sb_q.push_back(4);
        do_measure(4, 1'b0);
        sb_q.push_back(6);
        do_measure(6, 1'b0);
        checkOutput("rst_pre_valid", {31'd0, evt_valid}, 1);
        start_pulse = 1'b1;
        tick();
        start_pulse = 1'b0;
        for (int j = 1; j < 15; j++) tick();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_busy",     {31'd0, busy},      0);
        checkOutput("rst_async_valid",    {31'd0, evt_valid}, 0);
        checkOutput("rst_async_data",     {16'd0, evt_data},  0);
        checkOutput("rst_async_timeouts", {16'd0, timeout_count}, 0);
        checkOutput("rst_async_drops",    {16'd0, drop_count},    0);
        sb_q.delete();
        exp_timeouts = 0;
        tick();
        checkOutput("rst_hold_busy", {31'd0, busy}, 0);
        #2;
        rst_n       = 1'b1;
        start_pulse = 1'b1;
        enable      = 1'b1;
        evt_ready   = 1'b1;
        tick();
        start_pulse = 1'b0;
        checkOutput("rst_first_start_busy", {31'd0, busy}, 1);
        sb_q.push_back(3);
        for (int j = 1; j <= 3; j++) begin
            stop_pulse = (j == 3);
            tick();
        end
        stop_pulse = 1'b0;
        checkOutput("rst_after_valid",    {31'd0, evt_valid}, 1);
        checkOutput("rst_after_data",     {16'd0, evt_data},  3);
        checkOutput("rst_after_timeouts", {16'd0, timeout_count}, 0);
        tick();
        tick();

        checkOutput("sb_empty_end", sb_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
